// File: rtl/thresh_pkg.sv
// Types and constants for the threshold distribution path, shared by the
// WISHBONE threshold block, the aclk-side loader and the beamformer.
package thresh_pkg;

  localparam int THRESH_W = 18;
  localparam int NLANES   = 2;

  typedef logic [THRESH_W-1:0] thresh_t;

  // Beams are carried in pairs, one per lane, so an odd beam count rounds up.
  function automatic int ndualbeams(input int nbeams);
    return (nbeams + 1) / 2;
  endfunction

endpackage

// File: rtl/thresh_lane_chain.sv
// One lane of the threshold stream: a shadow shift chain (newest word at
// position 0) and a saturating count of words received since the last update.
module thresh_lane_chain
  import thresh_pkg::*;
#(
  parameter int DEPTH = 46,
  parameter int CNT_W = 6
) (
  input  logic                      aclk,
  input  logic                      aclk_rst,
  input  logic                      i_wr,
  input  logic [THRESH_W-1:0]       i_word,
  input  logic                      i_clr,
  output logic [DEPTH*THRESH_W-1:0] o_chain,
  output logic [CNT_W-1:0]          o_count
);

  logic [DEPTH*THRESH_W-1:0] r_chain;
  logic [CNT_W-1:0]          r_count;

  // NOTE: non-blocking assignments keep every register sampling the values
  // from before the edge, so the shift and the count update stay consistent.
  always_ff @(posedge aclk) begin
    if (aclk_rst) begin
      r_chain <= '0;
      r_count <= '0;
    end else begin
      if (i_wr) begin
        r_chain <= {r_chain[(DEPTH-1)*THRESH_W-1:0], i_word};
      end
      // A word arriving in the clear cycle starts the next load.
      if (i_clr) begin
        r_count <= i_wr ? CNT_W'(1) : '0;
      end else if (i_wr && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_chain = r_chain;
  assign o_count = r_count;

endmodule

// File: rtl/thresh_loader.sv
// Receives the two-lane threshold stream, validates complete loads and commits
// every beam's trigger threshold and reconstructed subthreshold in one cycle.
module thresh_loader
  import thresh_pkg::*;
#(
  parameter int                 NBEAMS       = 46,
  parameter logic [THRESH_W-1:0] TRIG_DEFAULT = 18'h3FFFF,
  parameter logic [THRESH_W-1:0] SUB_DEFAULT  = 18'h3FFFF,
  localparam int NDUALBEAMS = ndualbeams(NBEAMS),
  localparam int DEPTH      = 2 * NDUALBEAMS,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                         aclk,
  input  logic                         aclk_rst,
  input  logic [NLANES*THRESH_W-1:0]   thresh_i,
  input  logic [NLANES-1:0]            thresh_wr_i,
  input  logic [NLANES-1:0]            thresh_update_i,
  output logic [NBEAMS*THRESH_W-1:0]   trig_thresh_o,
  output logic [NBEAMS*THRESH_W-1:0]   sub_thresh_o,
  output logic                         commit_o,
  output logic                         load_err_o,
  output logic [NLANES*CNT_W-1:0]      lane_count_o
);

  logic [DEPTH*THRESH_W-1:0]  w_chain [NLANES];
  logic [CNT_W-1:0]           w_count [NLANES];
  logic [NBEAMS*THRESH_W-1:0] w_new_trig;
  logic [NBEAMS*THRESH_W-1:0] w_new_sub;
  logic                       w_load_ok;
  logic                       w_unused_update;

  logic                       r_commit_pending;
  logic                       r_commit;
  logic                       r_load_err;
  logic [NBEAMS*THRESH_W-1:0] r_trig;
  logic [NBEAMS*THRESH_W-1:0] r_sub;

  // The sender drives both update bits identically; only lane 0's is used.
  assign w_unused_update = thresh_update_i[1];

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    thresh_lane_chain #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
    ) u_chain (
      .aclk    (aclk),
      .aclk_rst(aclk_rst),
      .i_wr    (thresh_wr_i[l]),
      .i_word  (thresh_i[l*THRESH_W +: THRESH_W]),
      .i_clr   (r_commit_pending),
      .o_chain (w_chain[l]),
      .o_count (w_count[l])
    );
    assign lane_count_o[l*CNT_W +: CNT_W] = w_count[l];
  end

  // Chain slot 2k holds trig(pair k), slot 2k+1 holds trig - sub for that pair.
  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    localparam int LANE = b % 2;
    localparam int PAIR = b / 2;
    assign w_new_trig[b*THRESH_W +: THRESH_W] =
      w_chain[LANE][(2*PAIR)*THRESH_W +: THRESH_W];
    assign w_new_sub[b*THRESH_W +: THRESH_W] =
      w_chain[LANE][(2*PAIR)*THRESH_W +: THRESH_W] -
      w_chain[LANE][(2*PAIR+1)*THRESH_W +: THRESH_W];
  end

  assign w_load_ok = (w_count[0] == CNT_W'(DEPTH)) &&
                     (w_count[1] == CNT_W'(DEPTH));

  always_ff @(posedge aclk) begin
    if (aclk_rst) begin
      r_trig           <= {NBEAMS{TRIG_DEFAULT}};
      r_sub            <= {NBEAMS{SUB_DEFAULT}};
      r_commit_pending <= 1'b0;
      r_commit         <= 1'b0;
      r_load_err       <= 1'b0;
    end else begin
      r_commit_pending <= thresh_update_i[0];
      r_commit         <= 1'b0;
      if (r_commit_pending) begin
        if (w_load_ok) begin
          r_trig     <= w_new_trig;
          r_sub      <= w_new_sub;
          r_commit   <= 1'b1;
          r_load_err <= 1'b0;
        end else begin
          r_load_err <= 1'b1;
        end
      end
    end
  end

  assign trig_thresh_o = r_trig;
  assign sub_thresh_o  = r_sub;
  assign commit_o      = r_commit;
  assign load_err_o    = r_load_err;

endmodule
